// File: rtl/sdm_ctrl_pkg.sv
// Shared types and bundle layout for the SDM stream controller.
// A bundle is packed as {y1, y0, x1, x0} with x0 in the least significant bits.
package sdm_ctrl_pkg;

    localparam int unsigned XW       = 28;
    localparam int unsigned YW       = 36;
    localparam int unsigned BUNDLE_W = 128;

    localparam int unsigned X0_LSB = 0;
    localparam int unsigned X1_LSB = X0_LSB + XW;
    localparam int unsigned Y0_LSB = X1_LSB + XW;
    localparam int unsigned Y1_LSB = Y0_LSB + YW;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StMute,
        StRecover
    } state_e;

    function automatic logic [BUNDLE_W-1:0] pack_bundle(
        input logic [XW-1:0] x0,
        input logic [XW-1:0] x1,
        input logic [YW-1:0] y0,
        input logic [YW-1:0] y1
    );
        logic [BUNDLE_W-1:0] b;
        b                  = '0;
        b[X0_LSB +: XW]    = x0;
        b[X1_LSB +: XW]    = x1;
        b[Y0_LSB +: YW]    = y0;
        b[Y1_LSB +: YW]    = y1;
        return b;
    endfunction

endpackage

// File: rtl/sdm_bundle_fifo2.sv
// Two-entry synchronous FIFO for sample bundles; flush overrides push and pop.
module sdm_bundle_fifo2
    import sdm_ctrl_pkg::*;
(
    input  logic                pclk,
    input  logic                preset,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [BUNDLE_W-1:0] wdata,
    output logic [BUNDLE_W-1:0] rdata,
    output logic [1:0]          count
);

    logic [BUNDLE_W-1:0] mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !flush && (count_q != 2'd2);
    assign do_pop  = pop && !flush && (count_q != 2'd0);

    always_ff @(posedge pclk) begin
        if (preset || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge pclk) begin
        if (do_push && !preset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sdm_stream_ctrl.sv
// Sequencer feeding pipe_sdm: buffers bundles, holds them per DSD bit period,
// and drives modulator start/mute with underrun and overflow handling.
module sdm_stream_ctrl
    import sdm_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_BITS   = 1,
    parameter int unsigned MUTE_BITS   = 64,
    parameter int unsigned RECOVER_CYC = 32
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 enable,
    input  logic                 mute_req,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [XW-1:0] in_x0,
    input  logic signed [XW-1:0] in_x1,
    input  logic signed [YW-1:0] in_y0,
    input  logic signed [YW-1:0] in_y1,
    input  logic                 sdm_overflow,
    output logic                 sdm_start,
    output logic                 sdm_mute,
    output logic signed [XW-1:0] x0,
    output logic signed [XW-1:0] x1,
    output logic signed [YW-1:0] y0,
    output logic signed [YW-1:0] y1,
    output logic [7:0]           underrun_cnt,
    output logic [7:0]           overflow_cnt,
    output logic                 busy
);

    state_e        state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [15:0]   mute_cnt_q, mute_cnt_d;
    logic [15:0]   rec_cnt_q, rec_cnt_d;
    logic          start_q, start_d;
    logic          mute_q, mute_d;
    logic [7:0]    uflow_q, oflow_q;
    logic [BUNDLE_W-1:0] out_q;

    logic                fifo_pop, fifo_flush, fifo_push;
    logic [BUNDLE_W-1:0] fifo_head;
    logic [1:0]          fifo_count;
    logic                load, zero_out, uflow_inc, oflow_inc, load_pt;

    assign in_ready  = (fifo_count != 2'd2) && (state_q == StFill || state_q == StRun);
    assign fifo_push = in_valid && in_ready;
    assign load_pt   = phase_q && (hold_cnt_q == 8'(HOLD_BITS - 1));

    sdm_bundle_fifo2 u_fifo (
        .pclk  (pclk),
        .preset(preset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (pack_bundle(in_x0, in_x1, in_y0, in_y1)),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            hold_cnt_q <= 8'd0;
            mute_cnt_q <= 16'd0;
            rec_cnt_q  <= 16'd0;
            start_q    <= 1'b0;
            mute_q     <= 1'b1;
            out_q      <= '0;
            uflow_q    <= 8'd0;
            oflow_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hold_cnt_q <= hold_cnt_d;
            mute_cnt_q <= mute_cnt_d;
            rec_cnt_q  <= rec_cnt_d;
            start_q    <= start_d;
            mute_q     <= mute_d;
            if (load) begin
                out_q <= fifo_head;
            end else if (zero_out) begin
                out_q <= '0;
            end
            if (uflow_inc && uflow_q != 8'hFF) begin
                uflow_q <= uflow_q + 8'd1;
            end
            if (oflow_inc && oflow_q != 8'hFF) begin
                oflow_q <= oflow_q + 8'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        mute_cnt_d = mute_cnt_q;
        rec_cnt_d  = rec_cnt_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        load       = 1'b0;
        uflow_inc  = 1'b0;
        oflow_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StFill;
            end
            StFill: begin
                if (!enable) begin
                    state_d    = StIdle;
                    fifo_flush = 1'b1;
                end else if (fifo_count == 2'd2) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (sdm_overflow) begin
                    state_d = StRecover;
                end else if (!enable) begin
                    state_d = StMute;
                end else if (load_pt) begin
                    if (fifo_count == 2'd0) begin
                        state_d   = StMute;
                        uflow_inc = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            StMute: begin
                if (sdm_overflow) begin
                    state_d = StRecover;
                end else if (phase_q) begin
                    if (mute_cnt_q == 16'd1) begin
                        fifo_flush = 1'b1;
                        state_d    = enable ? StFill : StIdle;
                    end else begin
                        mute_cnt_d = mute_cnt_q - 16'd1;
                    end
                end
            end
            StRecover: begin
                if (rec_cnt_q == 16'd1) begin
                    state_d = enable ? StFill : StIdle;
                end else begin
                    rec_cnt_d = rec_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StMute && state_q != StMute) begin
            mute_cnt_d = 16'(MUTE_BITS);
        end
        if (state_d == StRecover) begin
            fifo_flush = 1'b1;
            if (state_q != StRecover) begin
                rec_cnt_d = 16'(RECOVER_CYC);
                oflow_inc = 1'b1;
            end
        end

        if (state_d != StRun) begin
            hold_cnt_d = 8'd0;
        end else if (state_q == StRun && phase_q) begin
            hold_cnt_d = (hold_cnt_q == 8'(HOLD_BITS - 1)) ? 8'd0 : hold_cnt_q + 8'd1;
        end
    end

    // Output logic (registered controls)
    always_comb begin
        start_d  = (state_d == StRun) || (state_d == StMute);
        mute_d   = (state_d == StRun) ? mute_req : 1'b1;
        phase_d  = start_d && start_q && !phase_q;
        zero_out = (state_d == StRecover) || (state_d == StIdle);
    end

    assign sdm_start    = start_q;
    assign sdm_mute     = mute_q;
    assign x0           = out_q[X0_LSB +: XW];
    assign x1           = out_q[X1_LSB +: XW];
    assign y0           = out_q[Y0_LSB +: YW];
    assign y1           = out_q[Y1_LSB +: YW];
    assign underrun_cnt = uflow_q;
    assign overflow_cnt = oflow_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: doc/sdm_stream_ctrl.md
Name: sdm_stream_ctrl

Overview:
Sequencer in front of pipe_sdm. It buffers interpolated sample bundles (x0, x1, y0, y1) from the upstream interpolator and presents them to the modulator stably across each 2-pclk DSD bit period. It also drives the modulator's start/mute controls: soft-mute on disable or underrun, and forced restart after modulator overflow. Underrun and overflow events are counted for the status registers.

Parameters:
HOLD_BITS, 1, DSD bit periods each sample bundle is held (1..255)
MUTE_BITS, 64, DSD bit periods spent muted before leaving MUTE (1..65535)
RECOVER_CYC, 32, pclk cycles start is held low after an overflow (1..65535)

Ports:
pclk  in  1  master clock, 45.1584 MHz
preset  in  1  synchronous active-high reset
enable  in  1  playback enable
mute_req  in  1  host mute, passed through while running
in_valid  in  1  upstream bundle valid
in_ready  out  1  bundle accepted when in_valid & in_ready at pclk edge
in_x0, in_x1  in  28 each  signed input samples
in_y0, in_y1  in  36 each  signed dither/offset terms
sdm_overflow  in  1  sticky overflow flag from modulator
sdm_start  out  1  modulator start (low = modulator held in reset)
sdm_mute  out  1  modulator mute
x0, x1  out  28 each  samples to modulator
y0, y1  out  36 each  terms to modulator
underrun_cnt  out  8  saturating count of underruns
overflow_cnt  out  8  saturating count of overflows
busy  out  1  state != IDLE

Behaviour:
- Reset (preset=1 at an edge): state IDLE, FIFO empty, phase=0, sdm_start=0, sdm_mute=1, x0/x1/y0/y1=0, both counters=0, busy=0. A mid-operation reset takes priority over every other event.
- Phase: toggles every pclk while sdm_start=1; forced to 0 when sdm_start=0. phase=1 marks the second pclk of a DSD bit.
- hold_cnt: counts 0..HOLD_BITS-1, advancing on phase=1 cycles in RUN.
- Load point: RUN & phase=1 & hold_cnt=HOLD_BITS-1. At this edge the FIFO head is popped into the x/y output registers. Outputs never change at any other edge in RUN.
- FIFO: 2 entries of 128 bits, packed as {y1, y0, x1, x0}.
  - in_ready = (count<2) & state in {FILL, RUN}. in_ready is combinational from registered state.
  - Push and pop in the same cycle are legal; count is unchanged.
- States:
  - IDLE: outputs as at reset. enable=1 moves to FILL on the next edge.
  - FILL: sdm_start=0, sdm_mute=1. When count=2, pop the head into the outputs, set sdm_start=1 and phase=0, and move to RUN, all on one edge. enable=0 moves to IDLE and flushes the FIFO.
  - RUN: sdm_start=1, sdm_mute=mute_req registered one cycle. Transition priority:
    1. sdm_overflow=1 goes to RECOVER.
    2. Otherwise enable=0 goes to MUTE.
    3. Otherwise, at a load point with count=0 (underrun): go to MUTE, increment underrun_cnt, and hold the previous outputs.
  - MUTE: sdm_start=1, sdm_mute=1, in_ready=0, outputs held. mute_cnt loads MUTE_BITS on entry and decrements on each phase=1 cycle. At mute_cnt=0, flush the FIFO, then go to FILL if enable=1, else IDLE. sdm_overflow=1 goes to RECOVER (priority over the count).
  - RECOVER: increment overflow_cnt on entry. sdm_start=0, sdm_mute=1, outputs zeroed, FIFO flushed. Hold for RECOVER_CYC pclk, then go to FILL if enable=1, else IDLE. sdm_overflow is ignored in this state, because start low clears the modulator's flag.
- Counters saturate at 8'hFF.
- sdm_start and sdm_mute are registered, with no combinational path from any input.

Decomposition:
- Package sdm_ctrl_pkg holds:
  - state encoding: IDLE, FILL, RUN, MUTE, RECOVER
  - widths: XW=28, YW=36, BUNDLE_W=128
  - the pack/unpack field offsets
- Sub-module sdm_bundle_fifo2: a 2-entry, 128-bit synchronous FIFO with push, pop, flush and count.

Test Plan:
- Start-up: enable=1 with in_valid held high and bundles x0=1..N. The first two bundles are accepted in consecutive cycles; sdm_start rises on the edge after count reaches 2, with x0=1 already on the outputs. x0 then steps by 1 every 2 pclk (HOLD_BITS=1), and every 8 pclk when HOLD_BITS=4.
- Underrun: in RUN, drop in_valid. At the next load point with the FIFO empty, underrun_cnt goes 0→1 and sdm_mute=1. The outputs keep the last bundle for MUTE_BITS×2 pclk, then the state is FILL.
- Overflow: pulse sdm_overflow=1 in RUN. Next edge: sdm_start=0, outputs=0, overflow_cnt=1. sdm_start stays low for exactly RECOVER_CYC=32 pclk, then refill begins. An overflow pulse during RECOVER leaves the count unchanged.
- Disable: enable=0 in RUN gives sdm_mute=1 within 1 cycle. After 64 DSD periods the state is IDLE, sdm_start=0 and in_ready=0. enable=0 during FILL goes to IDLE on the next edge.
- Simultaneous: sdm_overflow=1 and enable=0 on the same RUN cycle goes to RECOVER, not MUTE. Push and pop on the same load edge keep count unchanged, e.g. 1 stays 1.
- Reset mid-RUN: assert preset for 1 cycle. Next edge: sdm_start=0, sdm_mute=1, counters=0, in_ready=0, busy=0.
